dvp_pixel_tx: RTL and testbench
===============================

Name: dvp_pixel_tx

Overview:
- DVP camera-side transmitter: turns an RGB444 pixel stream into the OV7670-style pclk/vsync/href/data[7:0] bus.
- It is the sensor end of the link and feeds image_capture-type receivers in loopback and simulation.
- It lets frames be injected on-chip without a physical camera.
- It runs from one system clock and generates pclk as clk/2.

Parameters:
- H_ACTIVE, 640, active pixels per line (2 bytes each).
- V_ACTIVE, 480, active lines per frame.
- H_BLANK, 144, pclk periods with href low after each line's active bytes.
- VS_LINES, 3, lines with vsync high at frame start.
- VBP_LINES, 17, back-porch lines (vsync low, href low).
- VFP_LINES, 10, front-porch lines after the active region.
- CW, 12, width of the x and y counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  start/continue frames
- pix_data  in  16  pixel {4'h0,R4,G4,B4}; bits [15:8] are sent first
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  pixel accepted this clk when pix_valid&&pix_ready
- pattern_sel  in  1  select internal colour bars (see Optional Feature)
- pclk  out  1  pixel clock, clk/2
- vsync  out  1  frame sync, active high
- href  out  1  line valid, active high
- data  out  8  byte bus
- frame_start  out  1  1-clk pulse when vsync first rises
- frame_done  out  1  1-clk pulse at end of the last front-porch pclk
- underflow  out  1  1-clk pulse per pixel slot with no valid input

Behaviour:
- Reset (asynchronous, rst_n=0):
  - outputs: pclk=0, vsync=0, href=0, data=0, pix_ready=0, frame_start=0, frame_done=0, underflow=0.
  - state: IDLE, counters=0.
  - Reset mid-frame aborts immediately; no frame_done is issued.
- pclk: a phase register toggles every clk. A "tick" is the clk cycle in which pclk goes 1->0.
  - vsync, href and data update only on ticks, so they are stable at every pclk rising edge.
- Line length: L = 2*H_ACTIVE + H_BLANK pclk periods.
- FSM states, each line L pclks:
  - IDLE: no counting; on a tick with enable=1 -> VSYNC, and frame_start pulses on that clk.
  - VSYNC: VS_LINES lines, vsync=1, href=0.
  - VBP: VBP_LINES lines.
  - ACTIVE: V_ACTIVE lines, each 2*H_ACTIVE pclks href=1 then H_BLANK pclks href=0.
  - VFP: VFP_LINES lines.
  - After VFP, frame_done pulses, then -> VSYNC if enable=1, else IDLE.
- enable low mid-frame: the current frame completes.
- Byte phase 0 on an ACTIVE href tick:
  - pix_ready=1 for exactly that clk (combinational from state/phase, independent of pix_valid).
  - If pix_valid=1: data <= pix_data[15:8] and pix_data[7:0] is latched.
  - Else: data <= 8'h00, the held byte = 8'h00, and underflow pulses.
- Byte phase 1: data <= held byte.
- data = 8'h00 on every tick with href=0.
- Counters: x counts pclks within a line (0..L-1); y counts lines within the state. Both wrap to 0 at state end; counter width is CW, with no overflow for legal parameters.

Optional Feature:
- Macro: DVP_TX_TEST_PATTERN_EN.
- Defined, with pattern_sel=1:
  - pix_data/pix_valid are ignored and pix_ready stays 0.
  - Pixels come from an internal 8-bar generator: bar index = x_pixel*8/H_ACTIVE.
  - Colours in order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - underflow never pulses.
- pattern_sel is sampled only at frame start.
- Undefined: pattern_sel is ignored and the generator is not built.

Test Plan (H_ACTIVE=2, V_ACTIVE=2, H_BLANK=4, VS_LINES=1, VBP_LINES=1, VFP_LINES=1; L=8, frame=40 pclk=80 clk):
- Reset mid-frame:
  - Stimulus: rst_n low during ACTIVE.
  - Required: all outputs 0 within the same clk, no frame_done; after release with enable=1, frame_start is seen on the first tick.
- Byte order:
  - Stimulus: enable=1, pix_valid held 1, pix_data 16'h0F0F then 16'h0AA5.
  - Required: pclk rising edges sample data 0F, 0F, 0A, A5 with href=1, then 4 pclks of href=0 with data=00.
- Frame timing:
  - Stimulus: continuous enable.
  - Required: vsync high for 8 pclks, href rises at pclk 16 and 24, frame_done every 80 clk, frame_start 1 clk after each frame_done tick.
- Underflow:
  - Stimulus: pix_valid=0 during the second pixel slot.
  - Required: underflow pulses once, data 00, 00 for that pixel, and the line length is unchanged.
- Enable drop:
  - Stimulus: enable deasserted during VBP.
  - Required: frame completes, one frame_done, FSM returns to IDLE, vsync stays 0 thereafter.
- Test pattern (macro defined):
  - Stimulus: pattern_sel=1, H_ACTIVE=8.
  - Required: first line bytes 0F FF 0F F0 00 FF 00 F0 0F 0F 0F 00 00 0F 00 00, pix_ready stays 0.

Source files
------------

// File: rtl/dvp_pixel_tx.sv
// DVP camera-side transmitter: RGB444 pixel stream -> pclk/vsync/href/data[7:0], pclk = clk/2.
// Optional internal colour-bar source is built only when DVP_TX_TEST_PATTERN_EN is defined.
module dvp_pixel_tx #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 144,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10,
  parameter int CW        = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        pattern_sel,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        underflow
);

  localparam int L = 2 * H_ACTIVE + H_BLANK;
  localparam logic [CW-1:0] X_LAST = CW'(L - 1);
  localparam logic [CW-1:0] HBYTES = CW'(2 * H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACTIVE,
    S_VFP
  } state_t;

  state_t        state, nstate;
  logic [CW-1:0] x, y, nx, ny, y_last;
  logic          ph, tick, last_pos, start_now, nhref;
  logic          pat_mode, src_ok;
  logic [15:0]   src_word;
  logic [7:0]    held;

  // The tick is the clk in which pclk falls; bus outputs change only then.
  assign tick = ph;
  assign pclk = ph;

  always_comb begin
    case (state)
      S_VSYNC:  y_last = CW'(VS_LINES - 1);
      S_VBP:    y_last = CW'(VBP_LINES - 1);
      S_ACTIVE: y_last = CW'(V_ACTIVE - 1);
      S_VFP:    y_last = CW'(VFP_LINES - 1);
      default:  y_last = '0;
    endcase
  end

  // Counters describe the pclk period currently on the bus; nstate/nx/ny is the one the next tick launches.
  always_comb begin
    nstate   = state;
    nx       = x;
    ny       = y;
    last_pos = 1'b0;
    if (state == S_IDLE) begin
      if (enable) begin
        nstate = S_VSYNC;
        nx     = '0;
        ny     = '0;
      end
    end else if (x == X_LAST) begin
      nx = '0;
      if (y == y_last) begin
        ny = '0;
        case (state)
          S_VSYNC:  nstate = S_VBP;
          S_VBP:    nstate = S_ACTIVE;
          S_ACTIVE: nstate = S_VFP;
          S_VFP: begin
            last_pos = 1'b1;
            nstate   = enable ? S_VSYNC : S_IDLE;
          end
          default:  nstate = S_IDLE;
        endcase
      end else begin
        ny = y + CW'(1);
      end
    end else begin
      nx = x + CW'(1);
    end
  end

  assign nhref     = (nstate == S_ACTIVE) && (nx < HBYTES);
  assign start_now = tick && (nstate == S_VSYNC) && ((state == S_IDLE) || last_pos);
  assign pix_ready = tick && nhref && !nx[0] && !pat_mode;

`ifdef DVP_TX_TEST_PATTERN_EN
  logic [CW-1:0] x_pix;
  logic [2:0]    bar;
  logic [11:0]   bar_rgb;

  assign x_pix = nx >> 1;
  assign bar   = 3'((32'(x_pix) * 8) / H_ACTIVE);

  always_comb begin
    case (bar)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  // Source selection is frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_mode <= 1'b0;
    end else if (start_now) begin
      pat_mode <= pattern_sel;
    end
  end

  assign src_word = pat_mode ? {4'h0, bar_rgb} : pix_data;
  assign src_ok   = pat_mode || pix_valid;
`else
  logic unused_sel;
  assign unused_sel = pattern_sel;
  assign pat_mode   = 1'b0;
  assign src_word   = pix_data;
  assign src_ok     = pix_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
    end else if (tick) begin
      state <= nstate;
      x     <= nx;
      y     <= ny;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph          <= 1'b0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      data        <= 8'h00;
      held        <= 8'h00;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      ph          <= ~ph;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      // High during the tick clk that closes the last front-porch pclk.
      frame_done  <= !ph && last_pos;
      if (tick) begin
        vsync       <= (nstate == S_VSYNC);
        href        <= nhref;
        frame_start <= start_now;
        if (!nhref) begin
          data <= 8'h00;
        end else if (nx[0]) begin
          data <= held;
        end else if (src_ok) begin
          data <= src_word[15:8];
          held <= src_word[7:0];
        end else begin
          data      <= 8'h00;
          held      <= 8'h00;
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_pixel_tx.sv
// Scoreboard bench for dvp_pixel_tx: expected per-pclk bus words are built from frame geometry and pixel plan.
module tb_dvp_pixel_tx;
  localparam int HA = 2, VA = 2, HB = 4, VS = 1, VBP = 1, VFP = 1;
  localparam int L = 2 * HA + HB;
  localparam int NF = 3;
  localparam int FRAME_CLK = 2 * L * (VS + VBP + VA + VFP);

  logic        clk = 1'b0;
  logic        rst_n, enable, pix_valid, pattern_sel;
  logic [15:0] pix_data;
  logic        pix_ready, pclk, vsync, href, frame_start, frame_done, underflow;
  logic [7:0]  data;

  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [16:0] pq[$];
  logic [9:0]  exp_q[$];
  int          fd_q[$], fs_q[$];
  int          uf_cnt = 0, exp_uf = 0;
  bit          rec = 0, mon_go = 0, mon_done = 0;

  dvp_pixel_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP), .CW(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pattern_sel(pattern_sel), .pclk(pclk), .vsync(vsync), .href(href),
    .data(data), .frame_start(frame_start), .frame_done(frame_done),
    .underflow(underflow)
  );

`ifdef DVP_TX_TEST_PATTERN_EN
  logic       tp_en;
  logic       tp_ready, tp_pclk, tp_vsync, tp_href, tp_fs, tp_fd, tp_uf;
  logic [7:0] tp_data;

  dvp_pixel_tx #(
    .H_ACTIVE(8), .V_ACTIVE(1), .H_BLANK(4),
    .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .CW(12)
  ) tp_dut (
    .clk(clk), .rst_n(rst_n), .enable(tp_en),
    .pix_data(16'h0000), .pix_valid(1'b0), .pix_ready(tp_ready),
    .pattern_sel(1'b1), .pclk(tp_pclk), .vsync(tp_vsync), .href(tp_href),
    .data(tp_data), .frame_start(tp_fs), .frame_done(tp_fd),
    .underflow(tp_uf)
  );
`endif

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_lines(input bit vs, input int n);
    for (int i = 0; i < n * L; i++) exp_q.push_back({vs, 1'b0, 8'h00});
  endtask

  // Reference: one frame as a list of {vsync, href, data} per pclk period.
  task automatic build_frame(input int f);
    logic [15:0] d;
    bit          v;
    int          s;
    push_lines(1'b1, VS);
    push_lines(1'b0, VBP);
    for (int ln = 0; ln < VA; ln++) begin
      for (int p = 0; p < HA; p++) begin
        s = ln * HA + p;
        d = 16'($urandom) & 16'h0FFF;
        v = ($urandom_range(0, 7) != 0);
        if (f == 0 && s == 0) begin d = 16'h0F0F; v = 1'b1; end
        if (f == 0 && s == 1) begin d = 16'h0AA5; v = 1'b1; end
        if (f == 1 && s == 1) v = 1'b0;
        pq.push_back({v, d});
        if (!v) exp_uf++;
        exp_q.push_back({2'b01, v ? d[15:8] : 8'h00});
        exp_q.push_back({2'b01, v ? d[7:0] : 8'h00});
      end
      for (int b = 0; b < HB; b++) exp_q.push_back(10'h000);
    end
    push_lines(1'b0, VFP);
  endtask

  // Pixel source: holds the head of the plan until a ready slot takes it.
  initial begin
    bit took;
    pix_valid = 1'b0;
    pix_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (pq.size() > 0) begin
        pix_valid = pq[0][16];
        pix_data  = pq[0][15:0];
      end else begin
        pix_valid = 1'b0;
        pix_data  = 16'($urandom);
      end
      took = pix_ready;
      @(posedge clk);
      if (took && pq.size() > 0) void'(pq.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (rec) begin
      if (frame_done)  fd_q.push_back(cyc);
      if (frame_start) fs_q.push_back(cyc);
      if (underflow)   uf_cnt++;
    end
  end

  // Bus monitor: one scoreboard entry per pclk high phase once the first frame begins.
  initial begin
    bit         got;
    int         k;
    logic [9:0] e;
    wait (mon_go);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = frame_start;
    end
    if (!got) begin
      check("first_frame_start", 32'(got), 1);
      exp_q.delete();
    end
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      if (!pclk) @(negedge clk);
      if (!pclk) begin
        check("pclk_toggle", 32'(pclk), 1);
        exp_q.delete();
      end else begin
        e = exp_q.pop_front();
        check($sformatf("bus[%0d]", k), {22'h0, vsync, href, data}, {22'h0, e});
        k++;
      end
    end
    mon_done = 1'b1;
  end

  initial begin
    bit got;
`ifdef DVP_TX_TEST_PATTERN_EN
    logic [11:0] bars[8];
    logic [7:0]  tp_exp[16];
    int          k;
    bit          rdy_seen;
    tp_en = 1'b0;
`endif
    rst_n = 1'b0;
    enable = 1'b0;
    pattern_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pclk", 32'(pclk), 0);
    check("rst_vsync", 32'(vsync), 0);
    check("rst_href", 32'(href), 0);
    check("rst_data", 32'(data), 0);
    check("rst_pix_ready", 32'(pix_ready), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_underflow", 32'(underflow), 0);

    for (int f = 0; f < NF; f++) build_frame(f);
    for (int i = 0; i < 16; i++) exp_q.push_back(10'h000);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rec = 1'b1;
    mon_go = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 400 && fs_q.size() < NF; i++) @(negedge clk);
    check("frames_started", fs_q.size(), NF);
    // Dropping enable inside the last frame's back porch must still let it finish.
    repeat (20) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 600 && !mon_done; i++) @(negedge clk);
    check("monitor_done", 32'(mon_done), 1);
    rec = 1'b0;

    check("frame_done_count", fd_q.size(), NF);
    check("frame_start_count", fs_q.size(), NF);
    if (fd_q.size() == NF && fs_q.size() == NF) begin
      check("first_frame_len", fd_q[0] - fs_q[0], FRAME_CLK - 1);
      for (int i = 1; i < NF; i++) begin
        check($sformatf("frame_period[%0d]", i), fd_q[i] - fd_q[i-1], FRAME_CLK);
        check($sformatf("start_after_done[%0d]", i), fs_q[i] - fd_q[i-1], 1);
      end
    end
    check("underflow_count", uf_cnt, exp_uf);
    check("pixels_consumed", pq.size(), 0);
    check("idle_vsync", 32'(vsync), 0);

    // Asynchronous reset in the middle of an active line.
    enable = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = href;
    end
    check("href_seen", 32'(got), 1);
    fd_q.delete();
    rec = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pclk", 32'(pclk), 0);
    check("mid_rst_vsync", 32'(vsync), 0);
    check("mid_rst_href", 32'(href), 0);
    check("mid_rst_data", 32'(data), 0);
    check("mid_rst_pix_ready", 32'(pix_ready), 0);
    check("mid_rst_frame_done", 32'(frame_done), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("fs_before_tick", 32'(frame_start), 0);
    @(posedge clk);
    #1 check("fs_first_tick", 32'(frame_start), 1);
    check("vsync_first_tick", 32'(vsync), 1);
    check("no_done_after_rst", fd_q.size(), 0);
    rec = 1'b0;
    enable = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = frame_done;
    end
    check("frame_done_after_rst", 32'(got), 1);

`ifdef DVP_TX_TEST_PATTERN_EN
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    for (int i = 0; i < 8; i++) begin
      tp_exp[2*i]   = {4'h0, bars[i][11:8]};
      tp_exp[2*i+1] = bars[i][7:0];
    end
    tp_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = tp_fs;
    end
    check("tp_frame_start", 32'(got), 1);
    k = 0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 400 && k < 16; i++) begin
      @(negedge clk);
      if (tp_ready) rdy_seen = 1'b1;
      if (tp_pclk && tp_href) begin
        check($sformatf("tp_byte[%0d]", k), 32'(tp_data), 32'(tp_exp[k]));
        k++;
      end
    end
    check("tp_bytes_seen", k, 16);
    check("tp_pix_ready", 32'(rdy_seen), 0);
    tp_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
